// File: rtl/serial_frame_deser_pkg.sv
// Shared types and default constants for the serial frame deserializer.
package serial_deser_pkg;

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam int unsigned WIDTH       = 8;
    localparam int unsigned SYNC_LEN    = 4;
    localparam logic [3:0]  SYNC_PAT    = 4'b1011;
    localparam int unsigned FRAME_WORDS = 2;

endpackage

// File: rtl/serial_frame_deser_en_shift_reg.sv
// Enabled shift register, new bit enters at the LSB; synchronous clear wins over enable.
module en_shift_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic         d,
    output logic [W-1:0] q
);

    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;

    always_comb begin
        sr_d = {sr_q[W-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sr_q <= '0;
        end else if (en) begin
            sr_q <= sr_d;
        end
    end

    assign q = sr_q;

endmodule

// File: rtl/serial_frame_deser.sv
// Hunts for a sync pattern in a qualified serial stream, then deserializes
// FRAME_WORDS MSB-first words before returning to the hunt.
module serial_frame_deser #(
    parameter int unsigned            WIDTH       = serial_deser_pkg::WIDTH,
    parameter int unsigned            SYNC_LEN    = serial_deser_pkg::SYNC_LEN,
    parameter logic [SYNC_LEN-1:0]    SYNC_PAT    = serial_deser_pkg::SYNC_PAT,
    parameter int unsigned            FRAME_WORDS = serial_deser_pkg::FRAME_WORDS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             data_in,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    output logic             sync_found,
    output logic             in_frame,
    output logic [7:0]       word_idx
);

    import serial_deser_pkg::*;

    localparam int unsigned CW = $clog2(WIDTH);

    state_t             state_q;
    logic [CW-1:0]      bit_cnt_q;
    logic [7:0]         word_idx_q;
    logic [WIDTH-1:0]   par_out_q;
    logic               par_valid_q;
    logic               sync_found_q;
    logic               in_frame_q;

    logic [SYNC_LEN-1:0] hunt_q;
    logic [WIDTH-1:0]    data_q;
    logic [SYNC_LEN-1:0] hunt_d;
    logic [WIDTH-1:0]    word_d;
    logic                hunt_en;
    logic                data_en;
    logic                sync_hit;
    logic                word_done;
    logic                frame_done;
    logic                unused_msbs;

    // Match is evaluated on the value the hunt register is about to take,
    // so a sync completes on the same edge that shifts in its last bit.
    always_comb begin
        hunt_d     = {hunt_q[SYNC_LEN-2:0], data_in};
        word_d     = {data_q[WIDTH-2:0], data_in};
        hunt_en    = en && (state_q == HUNT);
        data_en    = en && (state_q == COLLECT);
        sync_hit   = hunt_en && (hunt_d == SYNC_PAT);
        word_done  = data_en && (bit_cnt_q == CW'(WIDTH - 1));
        frame_done = word_done && (word_idx_q == 8'(FRAME_WORDS - 1));
    end

    assign unused_msbs = ^{hunt_q[SYNC_LEN-1], data_q[WIDTH-1]};

    en_shift_reg #(.W(SYNC_LEN)) u_hunt_sr (
        .clk (clk),
        .clr (rst || sync_hit),
        .en  (hunt_en),
        .d   (data_in),
        .q   (hunt_q)
    );

    en_shift_reg #(.W(WIDTH)) u_data_sr (
        .clk (clk),
        .clr (rst),
        .en  (data_en),
        .d   (data_in),
        .q   (data_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HUNT;
            bit_cnt_q    <= '0;
            word_idx_q   <= '0;
            par_out_q    <= '0;
            par_valid_q  <= 1'b0;
            sync_found_q <= 1'b0;
            in_frame_q   <= 1'b0;
        end else begin
            par_valid_q  <= 1'b0;
            sync_found_q <= 1'b0;
            if (en) begin
                case (state_q)
                    HUNT: begin
                        if (sync_hit) begin
                            state_q      <= COLLECT;
                            sync_found_q <= 1'b1;
                            in_frame_q   <= 1'b1;
                            bit_cnt_q    <= '0;
                            word_idx_q   <= '0;
                        end
                    end
                    COLLECT: begin
                        if (word_done) begin
                            par_out_q   <= word_d;
                            par_valid_q <= 1'b1;
                            bit_cnt_q   <= '0;
                            if (frame_done) begin
                                state_q    <= HUNT;
                                in_frame_q <= 1'b0;
                                word_idx_q <= '0;
                            end else begin
                                word_idx_q <= word_idx_q + 8'd1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        state_q    <= HUNT;
                        in_frame_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign par_out    = par_out_q;
    assign par_valid  = par_valid_q;
    assign sync_found = sync_found_q;
    assign in_frame   = in_frame_q;
    assign word_idx   = word_idx_q;

endmodule

// File: tb/tb_serial_frame_deser.sv
// Scenario bench for serial_frame_deser: expected words are queued as they are sent.
module tb_serial_frame_deser;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       data_in;
    logic [7:0] par_out;
    logic       par_valid;
    logic       sync_found;
    logic       in_frame;
    logic [7:0] word_idx;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    int         sync_cnt = 0;
    int         pv_cnt = 0;
    int         cyc = 0;
    int         pv_cyc_prev = 0;
    int         pv_cyc_last = 0;
    logic       pv_prev = 1'b0;

    always #5 clk = ~clk;

    serial_frame_deser #(
        .WIDTH       (8),
        .SYNC_LEN    (4),
        .SYNC_PAT    (4'b1011),
        .FRAME_WORDS (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .data_in    (data_in),
        .par_out    (par_out),
        .par_valid  (par_valid),
        .sync_found (sync_found),
        .in_frame   (in_frame),
        .word_idx   (word_idx)
    );

    always @(posedge clk) cyc++;

    // Output monitor: every par_valid pulse pops one expected word.
    always @(negedge clk) begin
        if (sync_found === 1'b1) sync_cnt++;
        if (par_valid === 1'b1) begin
            logic [7:0] exp_w;
            pv_cnt++;
            pv_cyc_prev = pv_cyc_last;
            pv_cyc_last = cyc;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_word: got par_out=%h with no word expected", par_out);
            end else begin
                exp_w = exp_q.pop_front();
                if (par_out !== exp_w) begin
                    miscompares++;
                    $display("FAIL word_value: got %h want %h", par_out, exp_w);
                end
            end
            if (pv_prev === 1'b1) begin
                miscompares++;
                $display("FAIL valid_stretched: par_valid high on consecutive cycles, want single pulse");
            end
        end
        pv_prev = par_valid;
    end

    task automatic drive(input logic b, input logic e);
        @(negedge clk);
        data_in = b;
        en      = e;
    endtask

    task automatic send_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) drive(v[i], 1'b1);
    endtask

    task automatic settle();
        @(negedge clk);
        en = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk); rst = 1'b1; en = 1'b1; data_in = 1'b1;
        @(negedge clk); data_in = 1'b0;
        @(negedge clk); rst = 1'b0; en = 1'b0; data_in = 1'b1;
        #1;
        vectors++; if (par_out !== 8'h00) begin miscompares++; $display("FAIL reset_par_out: got %h want 00", par_out); end
        vectors++; if (par_valid !== 1'b0) begin miscompares++; $display("FAIL reset_par_valid: got %b want 0", par_valid); end
        vectors++; if (sync_found !== 1'b0) begin miscompares++; $display("FAIL reset_sync_found: got %b want 0", sync_found); end
        vectors++; if (in_frame !== 1'b0) begin miscompares++; $display("FAIL reset_in_frame: got %b want 0", in_frame); end
        vectors++; if (word_idx !== 8'd0) begin miscompares++; $display("FAIL reset_word_idx: got %0d want 0", word_idx); end
        send_bits(16'hB, 4);
        settle();
        vectors++; if (sync_found !== 1'b1) begin miscompares++; $display("FAIL sync_pulse: got %b want 1", sync_found); end
        vectors++; if (in_frame !== 1'b1) begin miscompares++; $display("FAIL sync_in_frame: got %b want 1", in_frame); end
        vectors++; if (sync_cnt != 1) begin miscompares++; $display("FAIL sync_count: got %0d want 1", sync_cnt); end
        settle();
        vectors++; if (sync_found !== 1'b0) begin miscompares++; $display("FAIL sync_single_cycle: got %b want 0", sync_found); end
    endtask

    task automatic test_basic_frame();
        int base = pv_cnt;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        send_bits(16'hA5, 8);
        send_bits(16'h3C, 8);
        settle();
        vectors++; if (pv_cnt != base + 2) begin miscompares++; $display("FAIL basic_word_count: got %0d want %0d", pv_cnt - base, 2); end
        vectors++; if (pv_cyc_last - pv_cyc_prev != 8) begin miscompares++; $display("FAIL basic_word_spacing: got %0d want 8", pv_cyc_last - pv_cyc_prev); end
        vectors++; if (in_frame !== 1'b0) begin miscompares++; $display("FAIL basic_in_frame: got %b want 0", in_frame); end
        vectors++; if (word_idx !== 8'd0) begin miscompares++; $display("FAIL basic_word_idx: got %0d want 0", word_idx); end
        settle();
        vectors++; if (par_out !== 8'h3C) begin miscompares++; $display("FAIL basic_par_hold: got %h want 3c", par_out); end
    endtask

    task automatic test_enable_gaps();
        int base;
        logic [7:0] w;
        send_bits(16'hB, 4);
        settle();
        vectors++; if (in_frame !== 1'b1) begin miscompares++; $display("FAIL gaps_sync: got in_frame=%b want 1", in_frame); end
        base = pv_cnt;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        for (int k = 0; k < 2; k++) begin
            w = (k == 0) ? 8'hA5 : 8'h3C;
            for (int i = 7; i >= 0; i--) begin
                drive(w[i], 1'b1);
                if (i == 6 || i == 3) begin
                    for (int g = 0; g < 3; g++) drive(~w[i], 1'b0);
                    if (k == 1 && i == 6) begin
                        #1;
                        vectors++; if (word_idx !== 8'd1) begin miscompares++; $display("FAIL gaps_word_idx: got %0d want 1", word_idx); end
                    end
                end
            end
        end
        settle();
        vectors++; if (pv_cnt != base + 2) begin miscompares++; $display("FAIL gaps_word_count: got %0d want 2", pv_cnt - base); end
        vectors++; if (in_frame !== 1'b0) begin miscompares++; $display("FAIL gaps_in_frame: got %b want 0", in_frame); end
    endtask

    task automatic test_overlap_hunt();
        int base_s = sync_cnt;
        send_bits(16'hA, 4);
        settle();
        vectors++; if (sync_cnt != base_s || in_frame !== 1'b0) begin miscompares++; $display("FAIL overlap_early_sync: got syncs=%0d in_frame=%b want 0 0", sync_cnt - base_s, in_frame); end
        send_bits(16'h3, 2);
        settle();
        vectors++; if (sync_cnt != base_s + 1) begin miscompares++; $display("FAIL overlap_sync: got %0d syncs want 1", sync_cnt - base_s); end
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        send_bits(16'hFF, 8);
        settle();
        vectors++; if (par_out !== 8'hFF) begin miscompares++; $display("FAIL overlap_word: got %h want ff", par_out); end
        send_bits(16'h00, 8);
        settle();
        vectors++; if (in_frame !== 1'b0) begin miscompares++; $display("FAIL overlap_in_frame: got %b want 0", in_frame); end
    endtask

    task automatic test_payload_pattern();
        int base_s;
        send_bits(16'hB, 4);
        settle();
        base_s = sync_cnt;
        exp_q.push_back(8'h0B);
        exp_q.push_back(8'hBB);
        send_bits(16'h0B, 8);
        send_bits(16'hBB, 8);
        settle();
        vectors++; if (sync_cnt != base_s) begin miscompares++; $display("FAIL payload_resync: got %0d extra syncs want 0", sync_cnt - base_s); end
        vectors++; if (par_out !== 8'hBB) begin miscompares++; $display("FAIL payload_last_word: got %h want bb", par_out); end
    endtask

    task automatic test_reset_mid_word();
        int base;
        send_bits(16'hB, 4);
        settle();
        base = pv_cnt;
        send_bits(16'h16, 5);
        @(negedge clk); rst = 1'b1; en = 1'b1; data_in = 1'b1;
        @(negedge clk); rst = 1'b0; en = 1'b0;
        #1;
        vectors++; if (in_frame !== 1'b0) begin miscompares++; $display("FAIL midrst_in_frame: got %b want 0", in_frame); end
        vectors++; if (par_out !== 8'h00) begin miscompares++; $display("FAIL midrst_par_out: got %h want 00", par_out); end
        settle();
        vectors++; if (pv_cnt != base) begin miscompares++; $display("FAIL midrst_valid: got %0d words want 0", pv_cnt - base); end
        send_bits(16'hB, 4);
        settle();
        vectors++; if (in_frame !== 1'b1) begin miscompares++; $display("FAIL midrst_resync: got in_frame=%b want 1", in_frame); end
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h81);
        send_bits(16'h5A, 8);
        settle();
        vectors++; if (par_out !== 8'h5A || word_idx !== 8'd1) begin miscompares++; $display("FAIL midrst_word: got %h idx %0d want 5a idx 1", par_out, word_idx); end
        send_bits(16'h81, 8);
        settle();
        vectors++; if (par_out !== 8'h81 || in_frame !== 1'b0) begin miscompares++; $display("FAIL midrst_frame_end: got %h in_frame %b want 81 0", par_out, in_frame); end
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        data_in = 1'b0;
        test_reset();
        test_basic_frame();
        test_enable_gaps();
        test_overlap_hunt();
        test_payload_pattern();
        test_reset_mid_word();
        settle();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL words_outstanding: got %0d undelivered want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
